// File: rtl/dot_serializer_pkg.sv
// Shared types and defaults for the dot_serializer slice.
package dot_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_t;

  localparam int unsigned DEF_WIDTH   = 5;
  localparam int unsigned DEF_CLK_DIV = 1;

endpackage

// File: rtl/dot_serializer_tick.sv
// Phase counter: tick is high on the last system-clock cycle of each
// CLK_DIV-long phase; clr restarts the phase.
module dot_serializer_tick #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = $clog2(CLK_DIV + 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst || clr || tick) cnt <= '0;
    else                     cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/dot_serializer.sv
// Serialises WIDTH-bit words MSB first to a 595-style driver (sclk/sdata/latch).
// Define DOT_SERIALIZER_BUF_EN for a one-entry pending-word buffer.
module dot_serializer
  import dot_serializer_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dot,
  input  logic             dot_vld,
  output logic             ready,
  output logic             sclk,
  output logic             sdata,
  output logic             latch,
  output logic             busy
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] word, word_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic             tick, accept;
  logic             sclk_d, sdata_d, latch_d, busy_d;

`ifdef DOT_SERIALIZER_BUF_EN
  logic [WIDTH-1:0] bufw, buf_n;
  logic             buf_full, buf_full_n;

  assign ready = (state == IDLE) || !buf_full;
`else
  assign ready = (state == IDLE);
`endif

  assign accept = dot_vld && ready;

  dot_serializer_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_n != state),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      word  <= '0;
      idx   <= '0;
`ifdef DOT_SERIALIZER_BUF_EN
      bufw     <= '0;
      buf_full <= 1'b0;
`endif
    end else begin
      state <= state_n;
      word  <= word_n;
      idx   <= idx_n;
`ifdef DOT_SERIALIZER_BUF_EN
      bufw     <= buf_n;
      buf_full <= buf_full_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    word_n  = word;
    idx_n   = idx;
`ifdef DOT_SERIALIZER_BUF_EN
    buf_n      = bufw;
    buf_full_n = buf_full;
`endif
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_n = SHIFT_LO;
          word_n  = dot;
          idx_n   = IDX_LAST;
        end
      end
      SHIFT_LO: if (tick) state_n = SHIFT_HI;
      SHIFT_HI: begin
        if (tick) begin
          if (idx == '0) begin
            state_n = LATCH;
          end else begin
            idx_n   = idx - IDX_W'(1);
            state_n = SHIFT_LO;
          end
        end
      end
      LATCH: begin
        if (tick) begin
`ifdef DOT_SERIALIZER_BUF_EN
          // A pending word (or one arriving right now) skips the IDLE cycle.
          if (buf_full) begin
            state_n    = SHIFT_LO;
            word_n     = bufw;
            idx_n      = IDX_LAST;
            buf_full_n = 1'b0;
          end else if (accept) begin
            state_n = SHIFT_LO;
            word_n  = dot;
            idx_n   = IDX_LAST;
          end else begin
            state_n = IDLE;
          end
`else
          state_n = IDLE;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
`ifdef DOT_SERIALIZER_BUF_EN
    if (accept && (state != IDLE) && !((state == LATCH) && tick)) begin
      buf_n      = dot;
      buf_full_n = 1'b1;
    end
`endif
  end

  // Outputs are decoded from the next state so the registered pins line up
  // with the state they describe.
  always_comb begin
    sclk_d  = (state_n == SHIFT_HI);
    latch_d = (state_n == LATCH);
    busy_d  = (state_n != IDLE);
    sdata_d = 1'b0;
    if ((state_n == SHIFT_LO) || (state_n == SHIFT_HI)) sdata_d = word_n[idx_n];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk  <= 1'b0;
      sdata <= 1'b0;
      latch <= 1'b0;
      busy  <= 1'b0;
    end else begin
      sclk  <= sclk_d;
      sdata <= sdata_d;
      latch <= latch_d;
      busy  <= busy_d;
    end
  end

endmodule

// File: tb/tb_dot_serializer.sv
// Directed bench for dot_serializer: CLK_DIV=1 and CLK_DIV=3 instances.
module tb_dot_serializer;

  logic       clk = 1'b0;
  logic       rst_a, vld_a, ready_a, sclk_a, sdata_a, latch_a, busy_a;
  logic [4:0] dot_a;
  logic       rst_b, vld_b, ready_b, sclk_b, sdata_b, latch_b, busy_b;
  logic [4:0] dot_b;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  dot_serializer #(.WIDTH(5), .CLK_DIV(1)) dut_a (
    .clk(clk), .rst(rst_a), .dot(dot_a), .dot_vld(vld_a), .ready(ready_a),
    .sclk(sclk_a), .sdata(sdata_a), .latch(latch_a), .busy(busy_a)
  );

  dot_serializer #(.WIDTH(5), .CLK_DIV(3)) dut_b (
    .clk(clk), .rst(rst_b), .dot(dot_b), .dot_vld(vld_b), .ready(ready_b),
    .sclk(sclk_b), .sdata(sdata_b), .latch(latch_b), .busy(busy_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b0; rst_b = 1'b0;
    step();
    step();
    checks++;
    if ({sclk_a, sdata_a, latch_a, busy_a, ready_a} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_a: got sclk/sdata/latch/busy/ready=%b expected 00001",
               {sclk_a, sdata_a, latch_a, busy_a, ready_a});
    end
    checks++;
    if ({sclk_b, sdata_b, latch_b, busy_b, ready_b} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_b: got sclk/sdata/latch/busy/ready=%b expected 00001",
               {sclk_b, sdata_b, latch_b, busy_b, ready_b});
    end
    rst_a = 1'b1; rst_b = 1'b1;
    step();
  endtask

  task automatic test_single();
    int         rises = 0;
    logic [4:0] bits = '0;
    logic       prev_sclk = 1'b0, prev_sdata = 1'b0, exp;
    dot_a = 5'b10110; vld_a = 1'b1;
    step();
    vld_a = 1'b0; dot_a = '0;
    for (int c = 1; c <= 13; c++) begin
      exp = (c <= 11);
      checks++;
      if (busy_a !== exp) begin
        errors++; $display("FAIL single_busy c%0d: got %b expected %b", c, busy_a, exp);
      end
      exp = (c == 11);
      checks++;
      if (latch_a !== exp) begin
        errors++; $display("FAIL single_latch c%0d: got %b expected %b", c, latch_a, exp);
      end
      exp = (c >= 12);
      checks++;
      if (ready_a !== exp) begin
        errors++; $display("FAIL single_ready c%0d: got %b expected %b", c, ready_a, exp);
      end
      if (sclk_a && !prev_sclk) begin
        rises++;
        bits = {bits[3:0], sdata_a};
        checks++;
        if (sdata_a !== prev_sdata) begin
          errors++; $display("FAIL single_setup c%0d: got %b expected %b", c, sdata_a, prev_sdata);
        end
      end
      prev_sclk = sclk_a; prev_sdata = sdata_a;
      step();
    end
    checks++;
    if (rises != 5) begin
      errors++; $display("FAIL single_rises: got %0d expected 5", rises);
    end
    checks++;
    if (bits !== 5'b10110) begin
      errors++; $display("FAIL single_bits: got %b expected 10110", bits);
    end
  endtask

  task automatic test_clkdiv3();
    int         rises = 0, first = 0, last = 0;
    logic [4:0] bits = '0;
    logic       prev_sclk = 1'b0, exp;
    dot_b = 5'b00001; vld_b = 1'b1;
    step();
    vld_b = 1'b0; dot_b = '0;
    for (int c = 1; c <= 36; c++) begin
      exp = (c <= 33);
      checks++;
      if (busy_b !== exp) begin
        errors++; $display("FAIL div3_busy c%0d: got %b expected %b", c, busy_b, exp);
      end
      exp = (c >= 31) && (c <= 33);
      checks++;
      if (latch_b !== exp) begin
        errors++; $display("FAIL div3_latch c%0d: got %b expected %b", c, latch_b, exp);
      end
      if (sclk_b && !prev_sclk) begin
        rises++;
        if (rises == 1) first = c;
        last = c;
        bits = {bits[3:0], sdata_b};
      end
      prev_sclk = sclk_b;
      step();
    end
    checks++;
    if (rises != 5) begin
      errors++; $display("FAIL div3_rises: got %0d expected 5", rises);
    end
    checks++;
    if (first != 4 || last != 28) begin
      errors++; $display("FAIL div3_period: got first=%0d last=%0d expected 4 28", first, last);
    end
    checks++;
    if (bits !== 5'b00001) begin
      errors++; $display("FAIL div3_bits: got %b expected 00001", bits);
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] exp5;
    dot_a = 5'b11111; vld_a = 1'b1;
    step();
    vld_a = 1'b0; dot_a = '0;
    step();
    step();
    rst_a = 1'b0;
    step();
    exp5 = 5'b00001;
    checks++;
    if ({sclk_a, sdata_a, latch_a, busy_a, ready_a} !== exp5) begin
      errors++;
      $display("FAIL midreset_outputs: got sclk/sdata/latch/busy/ready=%b expected %b",
               {sclk_a, sdata_a, latch_a, busy_a, ready_a}, exp5);
    end
    rst_a = 1'b1;
    for (int c = 0; c < 15; c++) begin
      step();
      checks++;
      if ({latch_a, busy_a, ready_a} !== 3'b001) begin
        errors++;
        $display("FAIL midreset_idle c%0d: got latch/busy/ready=%b expected 001",
                 c, {latch_a, busy_a, ready_a});
      end
    end
  endtask

`ifndef DOT_SERIALIZER_BUF_EN
  task automatic test_dropped();
    int         rises = 0, pulses = 0;
    logic [4:0] bits = '0;
    logic       prev_sclk = 1'b0, exp;
    dot_a = 5'b10101; vld_a = 1'b1;
    step();
    vld_a = 1'b0; dot_a = '0;
    for (int c = 1; c <= 16; c++) begin
      exp = (c <= 11);
      checks++;
      if (busy_a !== exp) begin
        errors++; $display("FAIL drop_busy c%0d: got %b expected %b", c, busy_a, exp);
      end
      exp = (c >= 12);
      checks++;
      if (ready_a !== exp) begin
        errors++; $display("FAIL drop_ready c%0d: got %b expected %b", c, ready_a, exp);
      end
      if (latch_a) pulses++;
      if (sclk_a && !prev_sclk) begin
        rises++;
        bits = {bits[3:0], sdata_a};
      end
      prev_sclk = sclk_a;
      if (c == 4) begin dot_a = 5'b01010; vld_a = 1'b1; end
      else begin dot_a = '0; vld_a = 1'b0; end
      step();
    end
    checks++;
    if (rises != 5 || bits !== 5'b10101) begin
      errors++; $display("FAIL drop_bits: got %0d rises bits %b expected 5 rises bits 10101", rises, bits);
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL drop_latch: got %0d latch cycles expected 1", pulses);
    end
  endtask
`else
  task automatic test_back_to_back();
    int         rises = 0;
    logic [9:0] bits = '0;
    logic       prev_sclk = 1'b0, exp;
    dot_a = 5'b11000; vld_a = 1'b1;
    step();
    vld_a = 1'b0; dot_a = '0;
    for (int c = 1; c <= 25; c++) begin
      exp = (c <= 22);
      checks++;
      if (busy_a !== exp) begin
        errors++; $display("FAIL b2b_busy c%0d: got %b expected %b", c, busy_a, exp);
      end
      exp = (c == 11) || (c == 22);
      checks++;
      if (latch_a !== exp) begin
        errors++; $display("FAIL b2b_latch c%0d: got %b expected %b", c, latch_a, exp);
      end
      exp = !((c >= 3) && (c <= 11));
      checks++;
      if (ready_a !== exp) begin
        errors++; $display("FAIL b2b_ready c%0d: got %b expected %b", c, ready_a, exp);
      end
      if (sclk_a && !prev_sclk) begin
        rises++;
        bits = {bits[8:0], sdata_a};
      end
      prev_sclk = sclk_a;
      if (c == 2) begin dot_a = 5'b00111; vld_a = 1'b1; end
      else begin dot_a = '0; vld_a = 1'b0; end
      step();
    end
    checks++;
    if (rises != 10 || bits !== 10'b1100000111) begin
      errors++; $display("FAIL b2b_bits: got %0d rises bits %b expected 10 rises bits 1100000111", rises, bits);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    vld_a = 1'b0; vld_b = 1'b0;
    dot_a = '0;   dot_b = '0;
    step();
    test_reset();
    test_single();
    test_clkdiv3();
    test_reset_mid();
`ifndef DOT_SERIALIZER_BUF_EN
    test_dropped();
`else
    test_back_to_back();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dot_serializer.md
# dot_serializer

Downstream stage of `ledarray`: takes each 5-bit column word `dot` that `ledarray` emits and shifts it out serially to an external shift-register LED driver (595-style: serial data, shift clock, storage latch). Accepts words over a valid/ready handshake, generates a divided shift clock, and pulses the latch once all bits are shifted.

## Interface
Parameters:
- `WIDTH`, 5, bits per word (matches `dot`); legal ≥ 1
- `CLK_DIV`, 1, system-clock cycles per shift-clock half-period; legal ≥ 1

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous reset, active-low
- `dot`  in  WIDTH  word from `ledarray`
- `dot_vld`  in  1  `dot` valid this cycle
- `ready`  out  1  block can accept a word this cycle (combinational from state)
- `sclk`  out  1  shift clock to driver, registered
- `sdata`  out  1  serial data, registered, MSB first
- `latch`  out  1  storage-latch strobe, registered
- `busy`  out  1  frame in progress (SHIFT or LATCH state), registered

One clock; reset is synchronous and active-low.

## Operation
- Accept: rising edge with `dot_vld && ready` captures `dot` into shift register; `dot_vld` with `ready` low is ignored (word dropped, no side effect).
- FSM states: IDLE, SHIFT_LO, SHIFT_HI, LATCH.
  - IDLE: `sclk=0`, `latch=0`, `busy=0`; on accept -> SHIFT_LO, bit index = WIDTH-1.
  - SHIFT_LO: `sclk=0`, `sdata=word[idx]`; after CLK_DIV cycles -> SHIFT_HI.
  - SHIFT_HI: `sclk=1`, `sdata` held; after CLK_DIV cycles: idx==0 -> LATCH, else idx-1, -> SHIFT_LO.
  - LATCH: `latch=1`, `sclk=0`; after CLK_DIV cycles -> IDLE (or SHIFT_LO with pending word, see Configuration).
- `ready` = (state==IDLE) without buffer.
- `sdata` returns to 0 in IDLE and LATCH.
- Phase counter width `$clog2(CLK_DIV+1)`, bit index width `$clog2(WIDTH)` (min 1); counter reloads 0 on every state change.

## Timing
- Reset (`rst==0` at an edge): state IDLE, `sclk=0`, `sdata=0`, `latch=0`, `busy=0`, shift register and buffer cleared; applies mid-frame, frame abandoned without latch pulse.
- Accept at edge 0 -> outputs reflect SHIFT_LO from cycle 1.
- Frame length: 2·WIDTH·CLK_DIV shift cycles + CLK_DIV latch cycles; WIDTH=5, CLK_DIV=1 -> 11 cycles busy, `ready` high again cycle 12.
- `sdata` stable CLK_DIV cycles before and through each `sclk` rising edge.
- Exactly one `latch` pulse (CLK_DIV cycles wide) per accepted word.

## Configuration
- `DOT_SERIALIZER_BUF_EN` defined: one-entry pending buffer. `ready` = IDLE || buffer empty. Word accepted while busy is stored; at LATCH exit with buffer full, buffer loads shift register and FSM goes directly to SHIFT_LO (no IDLE cycle), buffer empties. Accept in same cycle as buffer drain is not allowed (`ready` reflects pre-drain state: low).
- Undefined: no buffer; `ready` only in IDLE; words during busy are dropped.

## Structure
- `dot_serializer_pkg`: state enum typedef, default WIDTH/CLK_DIV localparams.
- Sub-module `dot_serializer_tick`: phase counter, parameter CLK_DIV, inputs `clk`, `rst`, `clr`; output `tick` high on last cycle of a phase.

## Test plan
- Reset mid-frame: accept 5'b11111, assert `rst=0` at cycle 4 -> next cycle all outputs 0, no `latch` pulse, `ready=1` after release.
- Single word, CLK_DIV=1: `dot=5'b10110` -> `sdata` sampled at `sclk` rises = 1,0,1,1,0; `latch` high cycle 11 only; `busy` cycles 1–11.
- CLK_DIV=3: `dot=5'b00001` -> `sclk` period 6 cycles, 5 rises, `latch` 3 cycles wide, frame 33 cycles.
- Dropped word (buffer off): accept 5'b10101, pulse `dot_vld` with 5'b01010 at cycle 5 -> only 1,0,1,0,1 shifted, one latch pulse.
- Back-to-back (`DOT_SERIALIZER_BUF_EN`): 5'b11000 then 5'b00111 at cycle 3 -> two latch pulses, second frame SHIFT_LO starts cycle 12, bits 0,0,1,1,1.
